// File: rtl/ctrl_pkg.sv
// Shared types for the six-instruction sequencer.
// Extension opcodes 6-9 are enabled by defining CTRL_EXT_OPS_EN.
package ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;
  localparam int REG_W   = 4;
  localparam int MADDR_W = 8;
  localparam int ALU_W   = 3;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
`ifdef CTRL_EXT_OPS_EN
    S_EXT    = 4'd9,
`endif
    S_HALT   = 4'd10
  } state_e;

  localparam logic [OP_W-1:0] OP_NOOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_STORE = 4'd1;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OP_W-1:0] OP_HALT  = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_OR    = 4'd7;
  localparam logic [OP_W-1:0] OP_AND   = 4'd8;
  localparam logic [OP_W-1:0] OP_INC   = 4'd9;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'd2;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'd4;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'd5;
  localparam logic [ALU_W-1:0] ALU_INC  = 3'd6;

  function automatic state_e decode_op(input logic [OP_W-1:0] op);
    state_e s;
    case (op)
      OP_STORE: s = S_STORE;
      OP_LOAD:  s = S_LOAD_A;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_HALT:  s = S_HALT;
`ifdef CTRL_EXT_OPS_EN
      OP_XOR, OP_OR, OP_AND, OP_INC: s = S_EXT;
`endif
      default:  s = S_NOOP;
    endcase
    return s;
  endfunction

`ifdef CTRL_EXT_OPS_EN
  function automatic logic [ALU_W-1:0] ext_alu(input logic [OP_W-1:0] op);
    logic [ALU_W-1:0] a;
    case (op)
      OP_XOR:  a = ALU_XOR;
      OP_OR:   a = ALU_OR;
      OP_AND:  a = ALU_AND;
      OP_INC:  a = ALU_INC;
      default: a = ALU_PASS;
    endcase
    return a;
  endfunction
`endif

endpackage

// File: rtl/ctrl_pc.sv
// Program counter: clear has priority over increment; wraps silently.
module ctrl_pc #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            up,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      clr:     pc_d = '0;
      up:      pc_d = pc_q + 1'b1;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/ctrl_fsm.sv
// Instruction sequencer: PC/IR ownership and registered Moore datapath controls.
// Extension opcodes (XOR/OR/AND/INC) are built in when CTRL_EXT_OPS_EN is defined.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int D_AW = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [INSTR_W-1:0]  I_data,
  output logic [PC_W-1:0]     I_addr,
  output logic [D_AW-1:0]     D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic [REG_W-1:0]    RF_W_addr,
  output logic                RF_W_en,
  output logic [REG_W-1:0]    RF_Ra_addr,
  output logic [REG_W-1:0]    RF_Rb_addr,
  output logic [ALU_W-1:0]    ALU_s,
  output logic [3:0]          State
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [D_AW-1:0]  d_addr_q, d_addr_d;
  logic             d_wr_q, d_wr_d;
  logic             rf_s_q, rf_s_d;
  logic [REG_W-1:0] w_addr_q, w_addr_d;
  logic             w_en_q, w_en_d;
  logic [REG_W-1:0] ra_q, ra_d;
  logic [REG_W-1:0] rb_q, rb_d;
  logic [ALU_W-1:0] alu_q, alu_d;

  ctrl_pc #(.PC_W(PC_W)) u_pc (
    .clk (Clock),
    .rst (Reset),
    .clr (state_q == S_INIT),
    .up  (state_q == S_FETCH),
    .pc  (I_addr)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
        ir_d    = '0;
      end
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = I_data;
      end
      S_DECODE: state_d = decode_op(ir_q[15:12]);
      S_LOAD_A: state_d = S_LOAD_B;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are precomputed for the state being entered, so they
  // register in step with the state itself.
  always_comb begin
    d_addr_d = '0;
    d_wr_d   = 1'b0;
    rf_s_d   = 1'b0;
    w_addr_d = '0;
    w_en_d   = 1'b0;
    ra_d     = '0;
    rb_d     = '0;
    alu_d    = ALU_PASS;
    case (state_d)
      S_STORE: begin
        d_addr_d = D_AW'(ir_d[7:0]);
        ra_d     = ir_d[11:8];
        d_wr_d   = 1'b1;
      end
      S_LOAD_A: begin
        d_addr_d = D_AW'(ir_d[7:0]);
        rf_s_d   = 1'b1;
      end
      S_LOAD_B: begin
        d_addr_d = D_AW'(ir_d[7:0]);
        rf_s_d   = 1'b1;
        w_addr_d = ir_d[11:8];
        w_en_d   = 1'b1;
      end
      S_ADD, S_SUB: begin
        ra_d     = ir_d[11:8];
        rb_d     = ir_d[7:4];
        w_addr_d = ir_d[3:0];
        w_en_d   = 1'b1;
        alu_d    = (state_d == S_ADD) ? ALU_ADD : ALU_SUB;
      end
`ifdef CTRL_EXT_OPS_EN
      S_EXT: begin
        ra_d     = ir_d[11:8];
        rb_d     = (ir_d[15:12] == OP_INC) ? '0 : ir_d[7:4];
        w_addr_d = ir_d[3:0];
        w_en_d   = 1'b1;
        alu_d    = ext_alu(ir_d[15:12]);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_INIT;
      ir_q     <= '0;
      d_addr_q <= '0;
      d_wr_q   <= 1'b0;
      rf_s_q   <= 1'b0;
      w_addr_q <= '0;
      w_en_q   <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      alu_q    <= ALU_PASS;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      d_addr_q <= d_addr_d;
      d_wr_q   <= d_wr_d;
      rf_s_q   <= rf_s_d;
      w_addr_q <= w_addr_d;
      w_en_q   <= w_en_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      alu_q    <= alu_d;
    end
  end

  assign State      = state_q;
  assign D_addr     = d_addr_q;
  assign D_wr       = d_wr_q;
  assign RF_s       = rf_s_q;
  assign RF_W_addr  = w_addr_q;
  assign RF_W_en    = w_en_q;
  assign RF_Ra_addr = ra_q;
  assign RF_Rb_addr = rb_q;
  assign ALU_s      = alu_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: per-cycle expected control vectors are
// queued as each program/reset is applied and drained cycle by cycle.
module tb_ctrl_fsm;
  import ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] I_data;
  logic [6:0]  I_addr;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s, RF_W_en;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s;

  logic [15:0] rom [128];

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] ia;
    logic [7:0] da;
    logic       dwr;
    logic       rfs;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  ctrl_fsm #(.PC_W(7), .D_AW(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .I_data     (I_data),
    .I_addr     (I_addr),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s      (ALU_s),
    .State      (State)
  );

  assign I_data = rom[I_addr];

  always #5 Clock = ~Clock;

  task automatic push(input string tag, input state_e s, input int ia,
                      input int da, input int dwr, input int rfs,
                      input int wa, input int wen, input int ra,
                      input int rb, input int alu);
    vec_t v;
    v.st  = s;
    v.ia  = 7'(ia);
    v.da  = 8'(da);
    v.dwr = 1'(dwr);
    v.rfs = 1'(rfs);
    v.wa  = 4'(wa);
    v.wen = 1'(wen);
    v.ra  = 4'(ra);
    v.rb  = 4'(rb);
    v.alu = 3'(alu);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pd(input string tag, input state_e s, input int ia);
    push(tag, s, ia, 0, 0, 0, 0, 0, 0, 0, 2);
  endtask

  task automatic step();
    vec_t  obs, ex;
    string t;
    @(posedge Clock);
    #1;
    obs = {State, I_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s};
    ex = exp_q.pop_front();
    t  = tag_q.pop_front();
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (st %0d/%0d ia %0d/%0d)",
             t, obs, ex, obs.st, ex.st, obs.ia, ex.ia);
    end
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2105;
    rom[1] = 16'h3123;
    rom[2] = 16'h130A;
    rom[3] = 16'h7124;
    rom[4] = 16'h4567;
    rom[5] = 16'h0000;
    rom[6] = 16'h5000;

    Reset = 1'b1;
    pd("reset_init", S_INIT, 0);
    step();
    Reset = 1'b0;

    pd("ld_fetch", S_FETCH, 0);
    pd("ld_decode", S_DECODE, 1);
    push("ld_a", S_LOAD_A, 1, 5, 0, 1, 0, 0, 0, 0, 2);
    push("ld_b", S_LOAD_B, 1, 5, 0, 1, 1, 1, 0, 0, 2);
    pd("add_fetch", S_FETCH, 1);
    pd("add_decode", S_DECODE, 2);
    push("add_exec", S_ADD, 2, 0, 0, 0, 3, 1, 1, 2, 0);
    pd("st_fetch", S_FETCH, 2);
    pd("st_decode", S_DECODE, 3);
    push("st_exec", S_STORE, 3, 10, 1, 0, 0, 0, 3, 0, 2);
    pd("or_fetch", S_FETCH, 3);
    pd("or_decode", S_DECODE, 4);
`ifdef CTRL_EXT_OPS_EN
    push("or_exec", S_EXT, 4, 0, 0, 0, 4, 1, 1, 2, 4);
`else
    pd("or_as_noop", S_NOOP, 4);
`endif
    pd("sub_fetch", S_FETCH, 4);
    pd("sub_decode", S_DECODE, 5);
    push("sub_exec", S_SUB, 5, 0, 0, 0, 7, 1, 5, 6, 1);
    pd("noop_fetch", S_FETCH, 5);
    pd("noop_decode", S_DECODE, 6);
    pd("noop_exec", S_NOOP, 6);
    pd("halt_fetch", S_FETCH, 6);
    pd("halt_decode", S_DECODE, 7);
    for (int i = 0; i < 20; i++) pd("halt_hold", S_HALT, 7);
    drain();

    Reset = 1'b1;
    pd("halt_reset", S_INIT, 0);
    step();
    Reset = 1'b0;
    pd("rs_fetch", S_FETCH, 0);
    pd("rs_decode", S_DECODE, 1);
    push("rs_ld_a", S_LOAD_A, 1, 5, 0, 1, 0, 0, 0, 0, 2);
    drain();

    Reset = 1'b1;
    pd("mid_load_reset", S_INIT, 0);
    step();
    Reset = 1'b0;
    pd("after_mid_reset", S_FETCH, 0);
    drain();

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    Reset = 1'b1;
    pd("wrap_reset", S_INIT, 0);
    step();
    Reset = 1'b0;
    for (int k = 0; k < 130; k++) begin
      logic [6:0] pc, nx;
      pc = 7'(k);
      nx = pc + 7'd1;
      pd("wrap_fetch", S_FETCH, int'(pc));
      pd("wrap_decode", S_DECODE, int'(nx));
      pd("wrap_noop", S_NOOP, int'(nx));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Instruction sequencer for the six-instruction processor, directly upstream of the ALU/register-file datapath. Owns the program counter and instruction register, fetches 16-bit words from instruction ROM, and decodes them into per-cycle datapath controls: register-file addresses and enables, data-memory address and write, RF write-source select, and the 3-bit ALU select. Each instruction runs as a Moore state sequence, and the block stops in HALT until reset.

## Interface
- PC_W, 7, PC / instruction-address width (128-word ROM)
- D_AW, 8, data-memory address width
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock; no other reset
- I_data  in  16  instruction word at address I_addr (combinational ROM, valid within the cycle)
- I_addr  out  PC_W  current PC
- D_addr  out  D_AW  data-memory address
- D_wr  out  1  data-memory write enable
- RF_s  out  1  RF write source: 1 = data memory, 0 = ALU Q
- RF_W_addr  out  4  RF write address
- RF_W_en  out  1  RF write enable
- RF_Ra_addr  out  4  RF read port A address
- RF_Rb_addr  out  4  RF read port B address
- ALU_s  out  3  ALU select: 0 add, 1 sub, 2 pass A, 3 xor, 4 or, 5 and, 6 inc
- State  out  4  current state encoding, for debug display

## Operation
- Instruction fields: op = IR[15:12].
  - ALU ops: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0].
  - LOAD: Rd = IR[11:8], addr = IR[7:0].
  - STORE: Ra = IR[11:8], addr = IR[7:0].
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT. With the extension macro: 6 XOR, 7 OR, 8 AND, 9 INC (Ra+1 to Rd).
- States and transitions:
  - INIT → FETCH
  - FETCH → DECODE
  - DECODE → NOOP / STORE / LOAD_A / ADD / SUB / HALT / EXT by op
  - LOAD_A → LOAD_B
  - NOOP, STORE, LOAD_B, ADD, SUB, EXT → FETCH
  - HALT → HALT
- Unlisted or disabled opcodes decode as NOOP.
- Per-state outputs. Defaults: D_wr = RF_W_en = RF_s = 0, ALU_s = 2, all addresses 0.
  - INIT: PC cleared to 0, IR cleared to 0.
  - FETCH: IR ← I_data; PC ← PC+1, 7-bit wrap 127 → 0.
  - STORE: D_addr = addr, RF_Ra_addr = Ra, D_wr = 1.
  - LOAD_A: D_addr = addr, RF_s = 1.
  - LOAD_B: D_addr = addr, RF_s = 1, RF_W_addr = Rd, RF_W_en = 1.
  - ADD / SUB / EXT: RF_Ra_addr = Ra, RF_Rb_addr = Rb, RF_W_addr = Rd, RF_W_en = 1, ALU_s = 0 / 1 / per-op.
  - HALT: all defaults; PC and IR frozen.
- All outputs are functions of state and IR only; there is no combinational path from I_data.

## Timing
- Reset asserted at an edge: state = INIT, PC = 0, IR = 0 after that edge, regardless of current state (including mid-LOAD and HALT).
- After reset, every output is at its default and I_addr = 0.
- Cycles per instruction, counted from FETCH: NOOP/STORE/ADD/SUB/EXT = 3, LOAD = 4, HALT = 2 then stays.
- At most one write strobe (D_wr or RF_W_en) is high per cycle, for exactly one cycle per instruction.
- The PC increments only in FETCH. I_addr during DECODE and execute states already points to the next instruction.
- PC wrap from 127 to 0 is silent; there is no flag.

## Configuration
- CTRL_EXT_OPS_EN defined: opcodes 6–9 decode to EXT with ALU_s 3/4/5/6. INC drives RF_Rb_addr = 0.
- CTRL_EXT_OPS_EN undefined: EXT state is absent, opcodes 6–15 execute as NOOP, and ALU_s only ever takes 0, 1 or 2.

## Structure
- Package ctrl_pkg:
  - state enum (4-bit, fixed encodings INIT = 0 … EXT = 9, used for State)
  - opcode localparams
  - ALU select localparams (ALU_ADD … ALU_INC)
  - instruction field slice widths
- Sub-module ctrl_pc: PC_W-bit register with clear/up/hold. The FSM, IR register and output decode live in ctrl_fsm.

## Test plan
- Reset, then ROM[0] = 16'h2_1_05 (LOAD R1 ← D[5]):
  - Cycle 1: INIT.
  - Cycle 2: FETCH, I_addr = 0.
  - LOAD_A: D_addr = 5, RF_s = 1, RF_W_en = 0.
  - LOAD_B: RF_W_en = 1, RF_W_addr = 1.
  - Then FETCH with I_addr = 1.
- ROM word 16'h3_1_2_3 (ADD): execute cycle has Ra = 1, Rb = 2, W = 3, ALU_s = 0, RF_W_en = 1 for exactly one cycle.
- ROM word 16'h1_3_0A (STORE R3 → D[10]): D_wr = 1, D_addr = 10, RF_Ra_addr = 3, RF_W_en = 0.
- ROM word 16'h5000 (HALT): holds State = HALT and I_addr constant for 20 cycles, all strobes 0. Reset then returns to INIT and I_addr = 0.
- Opcode 7 (OR): with CTRL_EXT_OPS_EN, ALU_s = 4 and RF_W_en pulses. Without it, NOOP, no strobes, back to FETCH after 3 cycles.
- Reset asserted during LOAD_A: next state INIT, RF_W_en never asserts. 128 NOOPs: I_addr wraps 127 → 0.
